tcdm_address_filter_ordered: RTL and testbench

- Parametrised TCDM-port access filter. Sits between an AXI-to-LINT bridge master port and the TCDM/L2 interconnect.
- Checks every request against N_RULES programmable address windows with per-rule read/write permissions.
- Blocked accesses receive an error response that is returned strictly in order with real responses. This depends on outstanding-transaction tracking.
- Captures the first blocked access for software and counts all blocked accesses.

---
 rtl/tcdm_filter_pkg.sv | 16 +
 rtl/tcdm_filter_order_fifo.sv | 50 +++++
 rtl/tcdm_address_filter_ordered.sv | 165 ++++++++++++++++
 tb/tb_tcdm_address_filter_ordered.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/tcdm_filter_pkg.sv
// Shared types and constants for the TCDM address filter.
package tcdm_filter_pkg;

  localparam int unsigned ATTR_VALID = 2;
  localparam int unsigned ATTR_REN   = 1;
  localparam int unsigned ATTR_WEN   = 0;

  localparam logic [31:0] ERR_DATA = 32'hBADE5505;

  typedef struct packed {
    logic valid;
    logic r_en;
    logic w_en;
  } rule_attr_t;

endpackage

// File: rtl/tcdm_filter_order_fifo.sv
// One-bit order FIFO: tags each granted request as real (0) or error (1).
module tcdm_filter_order_fifo #(
  parameter int unsigned DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic push_i,
  input  logic push_err_i,
  input  logic pop_i,
  output logic full_o,
  output logic empty_o,
  output logic head_o,
  output logic err_pending_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [DEPTH-1:0] mem_q;
  logic [PW-1:0]    wr_q, rd_q;
  logic [CW-1:0]    cnt_q, err_cnt_q;
  logic             push_ok, pop_ok;

  assign full_o        = (cnt_q == CW'(DEPTH));
  assign empty_o       = (cnt_q == '0);
  assign head_o        = mem_q[rd_q];
  assign err_pending_o = (err_cnt_q != '0);

  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q     <= '0;
      wr_q      <= '0;
      rd_q      <= '0;
      cnt_q     <= '0;
      err_cnt_q <= '0;
    end else begin
      if (push_ok) begin
        mem_q[wr_q] <= push_err_i;
        wr_q        <= wr_q + PW'(1);
      end
      if (pop_ok) rd_q <= rd_q + PW'(1);
      cnt_q     <= cnt_q + CW'(push_ok) - CW'(pop_ok);
      err_cnt_q <= err_cnt_q + CW'(push_ok & push_err_i) - CW'(pop_ok & mem_q[rd_q]);
    end
  end

endmodule

// File: rtl/tcdm_address_filter_ordered.sv
// TCDM access filter: rule-window permission check with in-order error responses
// and first-error capture / saturating blocked-access counter.
module tcdm_address_filter_ordered
  import tcdm_filter_pkg::*;
#(
  parameter int unsigned N_RULES         = 8,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned BE_WIDTH        = DATA_WIDTH / 8,
  parameter int unsigned GRAN_LSB        = 6,
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned ERR_CNT_WIDTH   = 8,
  parameter bit          ALIAS_EN        = 1'b0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          supervisor_mode_i,
  input  logic                          filter_en_i,
  input  logic                          req_i,
  input  logic [ADDR_WIDTH-1:0]         add_i,
  input  logic                          wen_i,
  input  logic [DATA_WIDTH-1:0]         wdata_i,
  input  logic [BE_WIDTH-1:0]           be_i,
  output logic                          gnt_o,
  output logic [DATA_WIDTH-1:0]         r_rdata_o,
  output logic                          r_valid_o,
  output logic                          r_opc_o,
  output logic                          req_o,
  output logic [ADDR_WIDTH-1:0]         add_o,
  output logic                          wen_o,
  output logic [DATA_WIDTH-1:0]         wdata_o,
  output logic [BE_WIDTH-1:0]           be_o,
  input  logic                          gnt_i,
  input  logic [DATA_WIDTH-1:0]         r_rdata_i,
  input  logic                          r_valid_i,
  input  logic [N_RULES*ADDR_WIDTH-1:0] rule_base_i,
  input  logic [N_RULES*ADDR_WIDTH-1:0] rule_end_i,
  input  logic [N_RULES*3-1:0]          rule_attr_i,
  input  logic                          err_clear_i,
  output logic                          err_valid_o,
  output logic [ADDR_WIDTH-1:0]         err_addr_o,
  output logic                          err_wen_o,
  output logic [ERR_CNT_WIDTH-1:0]      err_cnt_o
);

  localparam int unsigned CMP_W = ADDR_WIDTH - GRAN_LSB;

  logic [ADDR_WIDTH-1:0] add_eff;
  logic [CMP_W-1:0]      cmp_add, cmp_base, cmp_end;
  rule_attr_t            attr;
  logic                  perm_hit, allowed;
  logic                  unused_lsbs;
  logic                  full, empty, head, err_pending;
  logic                  head_err, push, pop, blocked_gnt;

  logic                     err_valid_q, err_valid_d;
  logic [ADDR_WIDTH-1:0]    err_addr_q, err_addr_d;
  logic                     err_wen_q, err_wen_d;
  logic [ERR_CNT_WIDTH-1:0] err_cnt_q, err_cnt_d;

  always_comb begin
    add_eff = add_i;
    if (ALIAS_EN && add_i[31:20] == 12'h000) add_eff[31:20] = 12'h1C0;
  end

  // Windows are compared at GRAN_LSB granularity; low bits of the rule ports are don't-care.
  always_comb begin
    perm_hit    = 1'b0;
    unused_lsbs = 1'b0;
    cmp_add     = add_eff[ADDR_WIDTH-1:GRAN_LSB];
    cmp_base    = '0;
    cmp_end     = '0;
    attr        = '0;
    for (int unsigned j = 0; j < N_RULES; j++) begin
      attr     = rule_attr_t'(rule_attr_i[j*3 +: 3]);
      cmp_base = rule_base_i[j*ADDR_WIDTH+GRAN_LSB +: CMP_W];
      cmp_end  = rule_end_i[j*ADDR_WIDTH+GRAN_LSB +: CMP_W];
      unused_lsbs = unused_lsbs ^ (^rule_base_i[j*ADDR_WIDTH +: GRAN_LSB])
                                ^ (^rule_end_i[j*ADDR_WIDTH +: GRAN_LSB]);
      if (attr.valid && cmp_add >= cmp_base && cmp_add < cmp_end &&
          (wen_i ? attr.r_en : attr.w_en))
        perm_hit = 1'b1;
    end
  end

  assign allowed = ~filter_en_i | supervisor_mode_i | perm_hit;

  tcdm_filter_order_fifo #(
    .DEPTH(MAX_OUTSTANDING)
  ) i_order_fifo (
    .clk          (clk),
    .rst          (rst),
    .push_i       (push),
    .push_err_i   (~allowed),
    .pop_i        (pop),
    .full_o       (full),
    .empty_o      (empty),
    .head_o       (head),
    .err_pending_o(err_pending)
  );

  // Allowed traffic stalls while any error is queued, so slave responses never race an error head.
  assign req_o       = req_i & allowed & ~full & ~err_pending;
  assign gnt_o       = allowed ? (gnt_i & ~full & ~err_pending) : (req_i & ~full);
  assign push        = req_i & gnt_o;
  assign blocked_gnt = push & ~allowed;

  assign add_o   = req_i ? add_eff : '0;
  assign wen_o   = req_i & wen_i;
  assign wdata_o = req_i ? wdata_i : '0;
  assign be_o    = req_i ? be_i : '0;

  assign head_err  = ~empty & head;
  assign r_valid_o = head_err | r_valid_i;
  assign r_opc_o   = head_err;
  assign r_rdata_o = head_err ? {(DATA_WIDTH/32){ERR_DATA}} : r_rdata_i;
  assign pop       = ~empty & (head_err | r_valid_i);

  always_comb begin
    err_valid_d = err_valid_q;
    err_addr_d  = err_addr_q;
    err_wen_d   = err_wen_q;
    err_cnt_d   = err_cnt_q;
    if (blocked_gnt) begin
      if (err_clear_i) begin
        err_valid_d = 1'b1;
        err_addr_d  = add_eff;
        err_wen_d   = wen_i;
        err_cnt_d   = ERR_CNT_WIDTH'(1);
      end else begin
        if (err_cnt_q != '1) err_cnt_d = err_cnt_q + ERR_CNT_WIDTH'(1);
        if (!err_valid_q) begin
          err_valid_d = 1'b1;
          err_addr_d  = add_eff;
          err_wen_d   = wen_i;
        end
      end
    end else if (err_clear_i) begin
      err_valid_d = 1'b0;
      err_addr_d  = '0;
      err_wen_d   = 1'b0;
      err_cnt_d   = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_valid_q <= 1'b0;
      err_addr_q  <= '0;
      err_wen_q   <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      err_valid_q <= err_valid_d;
      err_addr_q  <= err_addr_d;
      err_wen_q   <= err_wen_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign err_valid_o = err_valid_q;
  assign err_addr_o  = err_addr_q;
  assign err_wen_o   = err_wen_q;
  assign err_cnt_o   = err_cnt_q;

endmodule

// File: tb/tb_tcdm_address_filter_ordered.sv
// Directed bench for tcdm_address_filter_ordered (instantiated with aliasing enabled).
module tb_tcdm_address_filter_ordered;
  import tcdm_filter_pkg::*;

  localparam int unsigned NR = 8;
  localparam int unsigned DW = 32;
  localparam int unsigned AW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          supervisor_mode, filter_en, req, wen, gnt_o, r_valid_o, r_opc_o;
  logic [AW-1:0] add, add_o;
  logic [DW-1:0] wdata, r_rdata_o, wdata_o, r_rdata;
  logic [3:0]    be, be_o;
  logic          req_o, wen_o, gnt, r_valid, err_clear, err_valid, err_wen;
  logic [NR*AW-1:0] rule_base, rule_end;
  logic [NR*3-1:0]  rule_attr;
  logic [AW-1:0] err_addr;
  logic [7:0]    err_cnt;

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  tcdm_address_filter_ordered #(
    .N_RULES(NR), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .GRAN_LSB(6),
    .MAX_OUTSTANDING(4), .ERR_CNT_WIDTH(8), .ALIAS_EN(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .supervisor_mode_i(supervisor_mode), .filter_en_i(filter_en),
    .req_i(req), .add_i(add), .wen_i(wen), .wdata_i(wdata), .be_i(be),
    .gnt_o(gnt_o), .r_rdata_o(r_rdata_o), .r_valid_o(r_valid_o), .r_opc_o(r_opc_o),
    .req_o(req_o), .add_o(add_o), .wen_o(wen_o), .wdata_o(wdata_o), .be_o(be_o),
    .gnt_i(gnt), .r_rdata_i(r_rdata), .r_valid_i(r_valid),
    .rule_base_i(rule_base), .rule_end_i(rule_end), .rule_attr_i(rule_attr),
    .err_clear_i(err_clear), .err_valid_o(err_valid), .err_addr_o(err_addr),
    .err_wen_o(err_wen), .err_cnt_o(err_cnt)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rule0(input logic [2:0] attr);
    rule_base[31:0] = 32'h1C000000;
    rule_end[31:0]  = 32'h1C010000;
    rule_attr[2:0]  = attr;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(); step();
    #2;
    vecs++; if (err_valid !== 1'b0) begin errs++; $display("FAIL rst_err_valid: got %h exp 0", err_valid); end
    vecs++; if (err_cnt !== 8'd0) begin errs++; $display("FAIL rst_err_cnt: got %h exp 00", err_cnt); end
    vecs++; if (err_addr !== 32'h0) begin errs++; $display("FAIL rst_err_addr: got %h exp 0", err_addr); end
    vecs++; if ({gnt_o, r_valid_o, r_opc_o, req_o} !== 4'b0000) begin errs++; $display("FAIL rst_idle_outputs: got %b exp 0000", {gnt_o, r_valid_o, r_opc_o, req_o}); end
    step();
    rst = 1'b0;
  endtask

  task automatic test_pass_read();
    set_rule0(3'b111);
    req = 1'b1; add = 32'h1C000040; wen = 1'b1; gnt = 1'b1;
    #2;
    vecs++; if ({req_o, gnt_o} !== 2'b11) begin errs++; $display("FAIL rd_req_gnt: got %b exp 11", {req_o, gnt_o}); end
    vecs++; if (add_o !== 32'h1C000040) begin errs++; $display("FAIL rd_add_o: got %h exp 1c000040", add_o); end
    step();
    req = 1'b0; gnt = 1'b0; r_valid = 1'b1; r_rdata = 32'h12345678;
    #2;
    vecs++; if ({r_valid_o, r_opc_o} !== 2'b10) begin errs++; $display("FAIL rd_rsp_flags: got %b exp 10", {r_valid_o, r_opc_o}); end
    vecs++; if (r_rdata_o !== 32'h12345678) begin errs++; $display("FAIL rd_rsp_data: got %h exp 12345678", r_rdata_o); end
    step();
    r_valid = 1'b0;
    #2;
    vecs++; if (err_valid !== 1'b0) begin errs++; $display("FAIL rd_no_err: got %h exp 0", err_valid); end
  endtask

  task automatic test_blocked_write();
    set_rule0(3'b110);
    req = 1'b1; add = 32'h1C000080; wen = 1'b0; wdata = 32'hDEADBEEF;
    #2;
    vecs++; if ({req_o, gnt_o} !== 2'b01) begin errs++; $display("FAIL blk_req_gnt: got %b exp 01", {req_o, gnt_o}); end
    step();
    req = 1'b0;
    #2;
    vecs++; if ({r_valid_o, r_opc_o} !== 2'b11) begin errs++; $display("FAIL blk_rsp_flags: got %b exp 11", {r_valid_o, r_opc_o}); end
    vecs++; if (r_rdata_o !== 32'hBADE5505) begin errs++; $display("FAIL blk_rsp_data: got %h exp bade5505", r_rdata_o); end
    vecs++; if (err_addr !== 32'h1C000080) begin errs++; $display("FAIL blk_err_addr: got %h exp 1c000080", err_addr); end
    vecs++; if ({err_valid, err_wen, err_cnt} !== {1'b1, 1'b0, 8'd1}) begin errs++; $display("FAIL blk_capture: got %b/%b/%0d exp 1/0/1", err_valid, err_wen, err_cnt); end
    step();
    #2;
    vecs++; if (r_valid_o !== 1'b0) begin errs++; $display("FAIL blk_rsp_once: got %h exp 0", r_valid_o); end
  endtask

  task automatic test_ordering();
    // A: allowed read, granted
    req = 1'b1; add = 32'h1C000100; wen = 1'b1; gnt = 1'b1;
    step();
    // B: blocked write
    add = 32'h1C000104; wen = 1'b0; gnt = 1'b0;
    #2;
    vecs++; if ({req_o, gnt_o} !== 2'b01) begin errs++; $display("FAIL ord_b_gnt: got %b exp 01", {req_o, gnt_o}); end
    step();
    // C: allowed read, must stall behind queued error
    add = 32'h1C000108; wen = 1'b1; gnt = 1'b1;
    #2;
    vecs++; if ({req_o, gnt_o, r_valid_o} !== 3'b000) begin errs++; $display("FAIL ord_c_stall0: got %b exp 000", {req_o, gnt_o, r_valid_o}); end
    step();
    r_valid = 1'b1; r_rdata = 32'hAAAA0001;
    #2;
    vecs++; if ({r_valid_o, r_opc_o, r_rdata_o} !== {2'b10, 32'hAAAA0001}) begin errs++; $display("FAIL ord_a_rsp: got %b%b %h exp 10 aaaa0001", r_valid_o, r_opc_o, r_rdata_o); end
    vecs++; if (gnt_o !== 1'b0) begin errs++; $display("FAIL ord_c_stall1: got %h exp 0", gnt_o); end
    step();
    r_valid = 1'b0;
    #2;
    vecs++; if ({r_valid_o, r_opc_o, r_rdata_o} !== {2'b11, 32'hBADE5505}) begin errs++; $display("FAIL ord_b_rsp: got %b%b %h exp 11 bade5505", r_valid_o, r_opc_o, r_rdata_o); end
    vecs++; if (gnt_o !== 1'b0) begin errs++; $display("FAIL ord_c_stall2: got %h exp 0", gnt_o); end
    step();
    #2;
    vecs++; if ({req_o, gnt_o} !== 2'b11) begin errs++; $display("FAIL ord_c_gnt: got %b exp 11", {req_o, gnt_o}); end
    step();
    req = 1'b0; gnt = 1'b0; r_valid = 1'b1; r_rdata = 32'hCCCC0003;
    #2;
    vecs++; if ({r_valid_o, r_opc_o, r_rdata_o} !== {2'b10, 32'hCCCC0003}) begin errs++; $display("FAIL ord_c_rsp: got %b%b %h exp 10 cccc0003", r_valid_o, r_opc_o, r_rdata_o); end
    step();
    r_valid = 1'b0;
    #2;
    vecs++; if (err_cnt !== 8'd2) begin errs++; $display("FAIL ord_err_cnt: got %0d exp 2", err_cnt); end
  endtask

  task automatic test_full();
    set_rule0(3'b111);
    req = 1'b1; wen = 1'b1; gnt = 1'b1;
    for (int k = 0; k < 4; k++) begin
      add = 32'h1C000400 + 32'(4 * k);
      #2;
      vecs++; if (gnt_o !== 1'b1) begin errs++; $display("FAIL full_fill_gnt%0d: got %h exp 1", k, gnt_o); end
      step();
    end
    add = 32'h1C000500;
    #2;
    vecs++; if ({req_o, gnt_o} !== 2'b00) begin errs++; $display("FAIL full_5th_blocked: got %b exp 00", {req_o, gnt_o}); end
    step();
    r_valid = 1'b1; r_rdata = 32'h0;
    #2;
    vecs++; if (gnt_o !== 1'b0) begin errs++; $display("FAIL full_pop_same_cycle: got %h exp 0", gnt_o); end
    step();
    r_valid = 1'b0;
    #2;
    vecs++; if ({req_o, gnt_o} !== 2'b11) begin errs++; $display("FAIL full_5th_gnt: got %b exp 11", {req_o, gnt_o}); end
    step();
    req = 1'b0; gnt = 1'b0;
    for (int k = 1; k < 5; k++) begin
      r_valid = 1'b1; r_rdata = 32'(k);
      #2;
      vecs++; if ({r_valid_o, r_opc_o, r_rdata_o} !== {2'b10, 32'(k)}) begin errs++; $display("FAIL full_drain%0d: got %b%b %h exp 10 %h", k, r_valid_o, r_opc_o, r_rdata_o, 32'(k)); end
      step();
    end
    r_valid = 1'b0;
  endtask

  task automatic test_counter();
    set_rule0(3'b110);
    err_clear = 1'b1;
    step();
    err_clear = 1'b0;
    #2;
    vecs++; if ({err_valid, err_wen, err_cnt, err_addr} !== 42'd0) begin errs++; $display("FAIL clr_alone: got %b %b %0d %h exp all zero", err_valid, err_wen, err_cnt, err_addr); end
    req = 1'b1; wen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      add = 32'h1C000200 + 32'(4 * (i % 64));
      step();
    end
    req = 1'b0;
    #2;
    vecs++; if (err_cnt !== 8'd255) begin errs++; $display("FAIL cnt_saturate: got %0d exp 255", err_cnt); end
    vecs++; if (err_addr !== 32'h1C000200) begin errs++; $display("FAIL cnt_first_addr: got %h exp 1c000200", err_addr); end
    step();
    req = 1'b1; add = 32'h1C000300; err_clear = 1'b1;
    step();
    req = 1'b0; err_clear = 1'b0;
    #2;
    vecs++; if ({err_valid, err_cnt} !== {1'b1, 8'd1}) begin errs++; $display("FAIL clr_with_blk_cnt: got %b %0d exp 1 1", err_valid, err_cnt); end
    vecs++; if (err_addr !== 32'h1C000300) begin errs++; $display("FAIL clr_with_blk_addr: got %h exp 1c000300", err_addr); end
    step();
  endtask

  task automatic test_bypass();
    supervisor_mode = 1'b1;
    req = 1'b1; add = 32'h30000000; wen = 1'b0; gnt = 1'b1;
    #2;
    vecs++; if ({req_o, gnt_o, add_o} !== {2'b11, 32'h30000000}) begin errs++; $display("FAIL sup_forward: got %b%b %h exp 11 30000000", req_o, gnt_o, add_o); end
    step();
    req = 1'b0; gnt = 1'b0; r_valid = 1'b1; r_rdata = 32'h0;
    #2;
    vecs++; if ({r_valid_o, r_opc_o} !== 2'b10) begin errs++; $display("FAIL sup_rsp: got %b exp 10", {r_valid_o, r_opc_o}); end
    step();
    r_valid = 1'b0; supervisor_mode = 1'b0; filter_en = 1'b0;
    req = 1'b1;
    #2;
    vecs++; if (req_o !== 1'b1) begin errs++; $display("FAIL nofilter_forward: got %h exp 1", req_o); end
    req = 1'b0; filter_en = 1'b1;
    #2;
    vecs++; if (req_o !== 1'b0) begin errs++; $display("FAIL idle_req_o: got %h exp 0", req_o); end
  endtask

  task automatic test_alias();
    req = 1'b1; add = 32'h00000100; wen = 1'b1; gnt = 1'b0;
    #2;
    vecs++; if ({req_o, add_o} !== {1'b1, 32'h1C000100}) begin errs++; $display("FAIL alias_read: got %b %h exp 1 1c000100", req_o, add_o); end
    wen = 1'b0;
    #2;
    vecs++; if ({req_o, gnt_o} !== 2'b01) begin errs++; $display("FAIL alias_write_blocked: got %b exp 01", {req_o, gnt_o}); end
    req = 1'b0;
    step();
  endtask

  task automatic test_reset_mid();
    set_rule0(3'b110);
    req = 1'b1; add = 32'h1C000600; wen = 1'b1; gnt = 1'b1;
    step();
    req = 1'b0; gnt = 1'b0;
    rst = 1'b1;
    #2;
    vecs++; if ({err_valid, err_wen, err_cnt, err_addr} !== 42'd0) begin errs++; $display("FAIL rstmid_capture: got %b %b %0d %h exp all zero", err_valid, err_wen, err_cnt, err_addr); end
    step();
    rst = 1'b0;
    r_valid = 1'b1; r_rdata = 32'h55AA55AA;
    #2;
    vecs++; if ({r_valid_o, r_opc_o, r_rdata_o} !== {2'b10, 32'h55AA55AA}) begin errs++; $display("FAIL rstmid_orphan_rsp: got %b%b %h exp 10 55aa55aa", r_valid_o, r_opc_o, r_rdata_o); end
    step();
    r_valid = 1'b0;
    req = 1'b1; add = 32'h1C000700; wen = 1'b0;
    step();
    req = 1'b0;
    #2;
    vecs++; if ({r_valid_o, r_opc_o} !== 2'b11) begin errs++; $display("FAIL rstmid_fifo_empty: got %b exp 11", {r_valid_o, r_opc_o}); end
    step();
  endtask

  initial begin
    rst = 1'b1; supervisor_mode = 1'b0; filter_en = 1'b1;
    req = 1'b0; add = '0; wen = 1'b0; wdata = '0; be = 4'hF;
    gnt = 1'b0; r_rdata = '0; r_valid = 1'b0; err_clear = 1'b0;
    rule_base = '0; rule_end = '0; rule_attr = '0;
    test_reset();
    test_pass_read();
    test_blocked_write();
    test_ordering();
    test_full();
    test_counter();
    test_bypass();
    test_alias();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
